// File: rtl/mult.sv
// Sequential signed WIDTHxWIDTH radix-2 Booth multiplier.
// Controlled by a start/busy/done handshake; the product is returned as HI:LO.
module mult #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    multControl,
  input  logic signed [WIDTH-1:0] aInput,
  input  logic signed [WIDTH-1:0] bInput,
  output logic        [WIDTH-1:0] HI,
  output logic        [WIDTH-1:0] LO,
  output logic                    busy,
  output logic                    done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                  state;
  logic signed [WIDTH:0]   m_reg;
  logic signed [WIDTH:0]   acc;
  logic        [WIDTH-1:0] q;
  logic                    q_1;
  logic        [CNT_W-1:0] cnt;

  logic signed [WIDTH:0]   acc_sum;
  logic signed [WIDTH:0]   acc_n;
  logic        [WIDTH-1:0] q_n;
  logic                    q_1_n;
  logic                    start;

  // Booth recoding of the pair {Q[0], q_1}: 01 adds M, 10 subtracts M.
  function automatic logic signed [WIDTH:0] booth_add(
    input logic signed [WIDTH:0] a,
    input logic signed [WIDTH:0] m,
    input logic                  q0,
    input logic                  qm1
  );
    logic signed [WIDTH:0] r;
    case ({q0, qm1})
      2'b01:   r = a + m;
      2'b10:   r = a - m;
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic signed [2*WIDTH+1:0] booth_asr(
    input logic signed [WIDTH:0]   a,
    input logic        [WIDTH-1:0] qv,
    input logic                    qm1
  );
    logic signed [2*WIDTH+1:0] cat;
    cat = $signed({a, qv, qm1});
    return cat >>> 1;
  endfunction

  always_comb begin
    logic signed [2*WIDTH+1:0] shifted;
    acc_sum = booth_add(acc, m_reg, q[0], q_1);
    shifted = booth_asr(acc_sum, q, q_1);
    acc_n   = shifted[2*WIDTH+1:WIDTH+1];
    q_n     = shifted[WIDTH:1];
    q_1_n   = shifted[0];
  end

  // A new request is honoured from IDLE or DONE; requests during RUN are ignored.
  assign start = multControl && (state != S_RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      m_reg <= '0;
      acc   <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      cnt   <= '0;
      HI    <= '0;
      LO    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          acc <= acc_n;
          q   <= q_n;
          q_1 <= q_1_n;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= S_DONE;
            HI    <= acc_n[WIDTH-1:0];
            LO    <= q_n;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            state <= S_RUN;
            m_reg <= {aInput[WIDTH-1], aInput};
            acc   <= '0;
            q     <= bInput;
            q_1   <= 1'b0;
            cnt   <= CNT_W'(WIDTH);
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
